// File: rtl/axis_1553_rt_framer.sv
// MIL-STD-1553 RT message framer: filters commands for RT_ADDR, checks data word counts, frames AXI-Stream messages.
// Optional AXIS_1553_BROADCAST_EN: also accept RT address 31 as broadcast (transmit broadcasts are rejected).
module axis_1553_rt_framer #(
    parameter logic [4:0] RT_ADDR        = 5'd1,
    parameter int         TIMEOUT_CYCLES = 600,
    parameter int         CNT_W          = 16
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [15:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [15:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RX_DATA, TERM} state_t;

    state_t           state, state_nxt;
    logic [5:0]       words_left, words_left_nxt;
    logic [4:0]       sa_r, sa_nxt;
    logic [1:0]       code_r, code_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [15:0]      tdata_nxt;
    logic [7:0]       tuser_nxt;
    logic             tlast_nxt;
    logic             load;
    logic             msg_inc, err_inc;

    logic       is_cmd, par_ok, tr, mode, is_bcast, addr_match, out_free, accept;
    logic [4:0] rt, sa, wc;
    logic       unused_flags;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign is_cmd       = (s_axis_tuser[7:5] == 3'b100);
    assign par_ok       = s_axis_tuser[0];
    assign unused_flags = ^s_axis_tuser[4:1];
    assign rt           = s_axis_tdata[15:11];
    assign tr           = s_axis_tdata[10];
    assign sa           = s_axis_tdata[9:5];
    assign wc           = s_axis_tdata[4:0];
    assign mode         = (sa == 5'd0) || (sa == 5'd31);

`ifdef AXIS_1553_BROADCAST_EN
    assign is_bcast   = (rt == 5'd31);
    assign addr_match = (rt == RT_ADDR) || is_bcast;
`else
    assign is_bcast   = 1'b0;
    assign addr_match = (rt == RT_ADDR);
`endif

    // A command arriving mid-message is refused so it can be re-examined after the terminator.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state != TERM) && out_free &&
                           !((state == RX_DATA) && s_axis_tvalid && is_cmd);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        sa_nxt         = sa_r;
        code_nxt       = code_r;
        tmo_nxt        = tmo_cnt;
        load           = 1'b0;
        tdata_nxt      = s_axis_tdata;
        tuser_nxt      = {3'b010, sa_r};
        tlast_nxt      = 1'b0;
        msg_inc        = 1'b0;
        err_inc        = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_cmd) begin
                    if (!par_ok) begin
                        err_inc = 1'b1;
                    end else if (addr_match) begin
                        if (is_bcast && tr) begin
                            err_inc = 1'b1;
                        end else begin
                            load      = 1'b1;
                            tuser_nxt = {3'b100, sa};
                            sa_nxt    = sa;
                            tmo_nxt   = '0;
                            if (tr || (mode && !s_axis_tdata[4])) begin
                                tlast_nxt = 1'b1;
                                msg_inc   = 1'b1;
                            end else begin
                                state_nxt      = RX_DATA;
                                words_left_nxt = mode ? 6'd1 :
                                                 ((wc == 5'd0) ? 6'd32 : {1'b0, wc});
                            end
                        end
                    end
                end
            end
            RX_DATA: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                if (accept) begin
                    tmo_nxt = '0;
                    if (!par_ok) begin
                        code_nxt  = 2'd1;
                        err_inc   = 1'b1;
                        state_nxt = TERM;
                    end else begin
                        load           = 1'b1;
                        words_left_nxt = words_left - 6'd1;
                        if (words_left == 6'd1) begin
                            tlast_nxt = 1'b1;
                            msg_inc   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end else if (s_axis_tvalid && is_cmd) begin
                    code_nxt  = 2'd2;
                    err_inc   = 1'b1;
                    state_nxt = TERM;
                end else if (tmo_cnt == TMO_LAST) begin
                    code_nxt  = 2'd3;
                    err_inc   = 1'b1;
                    state_nxt = TERM;
                end
            end
            TERM: begin
                if (out_free) begin
                    load      = 1'b1;
                    tdata_nxt = 16'h0000;
                    tuser_nxt = {6'b000000, code_r};
                    tlast_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state         <= IDLE;
            words_left    <= '0;
            sa_r          <= '0;
            code_r        <= '0;
            tmo_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            msg_count     <= '0;
            err_count     <= '0;
        end else begin
            state      <= state_nxt;
            words_left <= words_left_nxt;
            sa_r       <= sa_nxt;
            code_r     <= code_nxt;
            tmo_cnt    <= tmo_nxt;
            msg_count  <= sat_inc(msg_count, msg_inc);
            err_count  <= sat_inc(err_count, err_inc);
            // Output register: a held beat only moves once the downstream takes it.
            if (load) begin
                m_axis_tdata  <= tdata_nxt;
                m_axis_tuser  <= tuser_nxt;
                m_axis_tlast  <= tlast_nxt;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
